// File: rtl/burst_memory_responder.sv
// rtl/burst_memory_responder.sv - line-organized memory serving fixed-length 64-bit bursts after a programmable latency
// Optional build macro: BURST_MEM_CHECK_EN adds the sticky protocol_err_o output.
module burst_memory_responder #(
  parameter int s_offset  = 5,
  parameter int ADDR_BITS = 5,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
`ifdef BURST_MEM_CHECK_EN
  ,
  output logic        protocol_err_o
`endif
);

  localparam int BEAT_W = s_offset - 3;
  localparam int BEATS  = 1 << BEAT_W;
  localparam int LINES  = 1 << ADDR_BITS;
  localparam int CNT_W  = 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_DRAIN
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      beat_d;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   op_rd_q;
  logic                   resp_q;
  logic [63:0]            burst_q;
  logic                   req_held;

  // Storage is one 64-bit word per beat of each line; never reset.
  logic [63:0] mem_q [LINES][BEATS];

  // Only the index field of the address selects a line; the rest aliases.
  logic unused_addr;
  assign unused_addr = ^address_i;

  assign req_held = op_rd_q ? read_i : write_i;
  assign beat_d   = beat_q + BEAT_W'(1);
  assign burst_o  = burst_q;
  assign resp_o   = resp_q;

  // Request sequencing: accept, count latency, stream beats, wait for release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      op_rd_q <= 1'b0;
      resp_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (read_i || write_i) begin
            op_rd_q <= read_i;
            idx_q   <= address_i[s_offset +: ADDR_BITS];
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_held) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            beat_q  <= '0;
            resp_q  <= 1'b1;
            if (op_rd_q) begin
              burst_q <= mem_q[idx_q][0];
            end
            state_q <= ST_BURST;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (beat_q == LAST_BEAT) begin
            resp_q  <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            beat_q <= beat_d;
            if (op_rd_q) begin
              burst_q <= mem_q[idx_q][beat_d];
            end
          end
        end
        ST_DRAIN: begin
          if (!read_i && !write_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write beats land at the edge closing each response cycle; reset blocks the write.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == ST_BURST && !op_rd_q) begin
      mem_q[idx_q][beat_q] <= burst_i;
    end
  end

`ifdef BURST_MEM_CHECK_EN
  logic        err_q;
  logic        prev_rd_q;
  logic        prev_wr_q;
  logic [31:0] addr_q;
  logic        active;
  logic        drop_err;
  logic        opp_err;
  logic        addr_err;

  assign active   = (state_q == ST_WAIT) || (state_q == ST_BURST);
  assign drop_err = (state_q == ST_BURST) && !req_held;
  assign opp_err  = active && (op_rd_q ? (write_i && !prev_wr_q) : (read_i && !prev_rd_q));
  assign addr_err = active && req_held && (address_i != addr_q);
  assign protocol_err_o = err_q;

  // Sticky initiator-misbehaviour flag plus the history it needs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q     <= 1'b0;
      prev_rd_q <= 1'b0;
      prev_wr_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      prev_rd_q <= read_i;
      prev_wr_q <= write_i;
      if (state_q == ST_IDLE && (read_i || write_i)) begin
        addr_q <= address_i;
      end
      if (drop_err || opp_err || addr_err) begin
        err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_burst_memory_responder.sv
// tb/tb_burst_memory_responder.sv - directed self-checking bench for burst_memory_responder
module tb_burst_memory_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic        read2_i = 1'b0;
  logic        write2_i = 1'b0;
  logic [31:0] address_i = '0;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic        resp_o;
  logic [63:0] burst2_o;
  logic        resp2_o;
`ifdef BURST_MEM_CHECK_EN
  logic        err_o;
  logic        err2_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] wdat [4];
  logic [63:0] rdat [4];
  logic [63:0] expd [4];
  int          first;
  int          nb;

  always #5 clk = ~clk;

  burst_memory_responder #(.s_offset(5), .ADDR_BITS(5), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o)
`ifdef BURST_MEM_CHECK_EN
    , .protocol_err_o(err_o)
`endif
  );

  burst_memory_responder #(.s_offset(5), .ADDR_BITS(5), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .read_i(read2_i), .write_i(write2_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst2_o), .resp_o(resp2_o)
`ifdef BURST_MEM_CHECK_EN
    , .protocol_err_o(err2_o)
`endif
  );

  // Issue one request on the LATENCY=4 instance; record first resp cycle, beat count and read data.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr);
    @(negedge clk);
    read_i = rd; write_i = wr; address_i = addr; burst_i = wdat[0];
    first = -1; nb = 0;
    for (int i = 0; i < 4; i++) rdat[i] = '0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) begin
        if (first < 0) first = c;
        if (nb < 4) begin
          burst_i  = wdat[nb];
          rdat[nb] = burst_o;
        end
        nb++;
      end else if (first >= 0) begin
        break;
      end
    end
    read_i = 1'b0; write_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", resp_o); end
    checks++; if (burst_o !== 64'h0) begin errors++; $display("FAIL reset_burst: got %h expected 0", burst_o); end
    checks++; if (resp2_o !== 1'b0) begin errors++; $display("FAIL reset_resp_l1: got %b expected 0", resp2_o); end
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    wdat[0] = 64'h1111_1111_1111_1111; wdat[1] = 64'h2222_2222_2222_2222;
    wdat[2] = 64'h3333_3333_3333_3333; wdat[3] = 64'h4444_4444_4444_4444;
    expd[0] = 64'h1111_1111_1111_1111; expd[1] = 64'h2222_2222_2222_2222;
    expd[2] = 64'h3333_3333_3333_3333; expd[3] = 64'h4444_4444_4444_4444;
    run_req(1'b0, 1'b1, 32'h0000_0040);
    checks++; if (first !== 4) begin errors++; $display("FAIL wr_first: got %0d expected 4", first); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL wr_beats: got %0d expected 4", nb); end
    run_req(1'b1, 1'b0, 32'h0000_0040);
    checks++; if (first !== 4) begin errors++; $display("FAIL rd_first: got %0d expected 4", first); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL rd_beats: got %0d expected 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== expd[i]) begin errors++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rdat[i], expd[i]); end
    end
  endtask

  task automatic test_latency1();
    logic exp_r;
    @(negedge clk);
    read2_i = 1'b1; address_i = 32'h0000_0040;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_r = (c <= 4);
      checks++;
      if (resp2_o !== exp_r) begin errors++; $display("FAIL l1_resp_c%0d: got %b expected %b", c, resp2_o, exp_r); end
    end
    read2_i = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp2_o !== 1'b0) begin errors++; $display("FAIL l1_no_retrigger_c%0d: got %b expected 0", c, resp2_o); end
    end
  endtask

  task automatic test_both_high();
    for (int i = 0; i < 4; i++) wdat[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    expd[0] = 64'h1111_1111_1111_1111; expd[1] = 64'h2222_2222_2222_2222;
    expd[2] = 64'h3333_3333_3333_3333; expd[3] = 64'h4444_4444_4444_4444;
    run_req(1'b1, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== expd[i]) begin errors++; $display("FAIL both_rd[%0d]: got %h expected %h", i, rdat[i], expd[i]); end
    end
    run_req(1'b1, 1'b0, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== expd[i]) begin errors++; $display("FAIL both_unchanged[%0d]: got %h expected %h", i, rdat[i], expd[i]); end
    end
  endtask

  task automatic test_alias();
    for (int i = 0; i < 4; i++) wdat[i] = 64'hAAAA_AAAA_AAAA_AAAA;
    run_req(1'b0, 1'b1, 32'h0000_0400);
    run_req(1'b1, 1'b0, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL alias[%0d]: got %h expected aaaaaaaaaaaaaaaa", i, rdat[i]); end
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_0040;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    read_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_resp: got %0d resp cycles expected 0", seen); end
    run_req(1'b1, 1'b0, 32'h0000_0040);
    checks++; if (first !== 4) begin errors++; $display("FAIL abort_next_first: got %0d expected 4", first); end
    checks++; if (rdat[3] !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL abort_next_data: got %h expected 4444444444444444", rdat[3]); end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] nw [4];
    int k;
    wdat[0] = 64'h0123_0000_0000_0000; wdat[1] = 64'h0123_0000_0000_0001;
    wdat[2] = 64'h0123_0000_0000_0002; wdat[3] = 64'h0123_0000_0000_0003;
    run_req(1'b0, 1'b1, 32'h0000_0060);
    nw[0] = 64'hBEEF_0000_0000_0000; nw[1] = 64'hBEEF_0000_0000_0001;
    nw[2] = 64'hBEEF_0000_0000_0002; nw[3] = 64'hBEEF_0000_0000_0003;
    k = 0;
    @(negedge clk);
    write_i = 1'b1; address_i = 32'h0000_0060; burst_i = nw[0];
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) begin
        burst_i = nw[k];
        if (k == 2) begin
          reset_n = 1'b0;
          break;
        end
        k++;
      end
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL rst_mid_reach_beat2: got %0d expected 2", k); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %b expected 0", resp_o); end
    checks++; if (burst_o !== 64'h0) begin errors++; $display("FAIL rst_mid_burst: got %h expected 0", burst_o); end
    reset_n = 1'b1; write_i = 1'b0;
    @(posedge clk);
    run_req(1'b1, 1'b0, 32'h0000_0060);
    expd[0] = 64'hBEEF_0000_0000_0000; expd[1] = 64'hBEEF_0000_0000_0001;
    expd[2] = 64'h0123_0000_0000_0002; expd[3] = 64'h0123_0000_0000_0003;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdat[i] !== expd[i]) begin errors++; $display("FAIL rst_mid_data[%0d]: got %h expected %h", i, rdat[i], expd[i]); end
    end
  endtask

  task automatic test_protocol_err();
`ifdef BURST_MEM_CHECK_EN
    int k;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_clean: got %b expected 0", err_o); end
    k = 0;
    @(negedge clk);
    write_i = 1'b1; address_i = 32'h0000_0080; burst_i = 64'h5;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) begin
        if (k == 1) write_i = 1'b0;
        k++;
      end else if (k > 0) begin
        break;
      end
    end
    write_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_drop: got %b expected 1", err_o); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_reset: got %b expected 0", err_o); end
    reset_n = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency1();
    test_both_high();
    test_alias();
    test_abort();
    test_reset_mid_write();
    test_protocol_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
